mult_unit: RTL and testbench

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit.sv | 171 +++++++++++++++++
 tb/tb_mult_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
`timescale 1ns/1ps
// mult_unit: iterative multiplier / multiply-accumulate unit.
// Handles MUL, MLA, UMULL, UMLAL, SMULL and SMLAL in a fixed WIDTH/BITS_PER_CYCLE
// cycles. Signed operands are multiplied as magnitudes. The sign and the
// accumulator are applied on the final BUSY cycle, so every opcode and every
// operand value takes the same number of cycles.
module mult_unit #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [2:0]       i_opcode,
   input  logic [3:0]       i_nzcv,
   input  logic [WIDTH-1:0] i_op1,
   input  logic [WIDTH-1:0] i_op2,
   input  logic [WIDTH-1:0] i_acc_lo,
   input  logic [WIDTH-1:0] i_acc_hi,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result_lo,
   output logic [WIDTH-1:0] o_result_hi,
   output logic [3:0]       o_nzcv,
   output logic             o_long
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = 2 * WIDTH;

   localparam logic [2:0] OP_MLA   = 3'd1;
   localparam logic [2:0] OP_UMULL = 3'd2;
   localparam logic [2:0] OP_UMLAL = 3'd3;
   localparam logic [2:0] OP_SMULL = 3'd4;
   localparam logic [2:0] OP_SMLAL = 3'd5;

   // A width that is not a whole number of digits cannot be retired in N cycles.
   if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
      $error("mult_unit: BITS_PER_CYCLE must divide WIDTH exactly");
   end

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                r_state, w_next_state;
   logic                  w_load, w_last;
   logic                  w_long, w_signed, w_acc_lo_en, w_acc_hi_en;
   logic [WIDTH-1:0]      w_abs1, w_abs2;
   logic [PW-1:0]         w_acc_init, w_partial, w_prod_next, w_signed_prod, w_sum;
   logic [PW-1:0]         r_mcand, r_prod, r_acc;
   logic [WIDTH-1:0]      r_mplier;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_neg, r_long_op;
   logic [1:0]            r_cv;
   logic [WIDTH-1:0]      r_result_lo, r_result_hi;
   logic [3:0]            r_nzcv;
   logic                  r_long;
   logic                  w_unused_nz;

   // Incoming N and Z are recomputed from the result, so only C and V are kept.
   assign w_unused_nz = ^i_nzcv[3:2];

   // State register.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic; i_start is only honoured in IDLE or DONE.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      w_next_state = r_state;
      w_load       = 1'b0;
      w_last       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_load = i_start;
            if (i_start) w_next_state = S_BUSY;
         end
         S_BUSY: begin
            w_last = (r_cnt == CNT_W'(N - 1));
            if (w_last) w_next_state = S_DONE;
         end
         S_DONE: begin
            w_load       = i_start;
            w_next_state = i_start ? S_BUSY : S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Opcode decode and operand conditioning at the start of an operation.
   always_comb begin
      w_long      = 1'b0;
      w_signed    = 1'b0;
      w_acc_lo_en = 1'b0;
      w_acc_hi_en = 1'b0;
      case (i_opcode)
         OP_MLA:   w_acc_lo_en = 1'b1;
         OP_UMULL: w_long = 1'b1;
         OP_UMLAL: begin w_long = 1'b1; w_acc_lo_en = 1'b1; w_acc_hi_en = 1'b1; end
         OP_SMULL: begin w_long = 1'b1; w_signed = 1'b1; end
         OP_SMLAL: begin
            w_long = 1'b1; w_signed = 1'b1; w_acc_lo_en = 1'b1; w_acc_hi_en = 1'b1;
         end
         default: ;  // MUL and the reserved codes behave as MUL
      endcase
      w_abs1     = (w_signed && i_op1[WIDTH-1]) ? -i_op1 : i_op1;
      w_abs2     = (w_signed && i_op2[WIDTH-1]) ? -i_op2 : i_op2;
      w_acc_init = {(w_acc_hi_en ? i_acc_hi : '0), (w_acc_lo_en ? i_acc_lo : '0)};
   end

   // One multiplier digit per BUSY cycle, then sign fix-up and accumulate.
   always_comb begin
      w_partial     = r_mcand * {{(PW - BITS_PER_CYCLE){1'b0}}, r_mplier[BITS_PER_CYCLE-1:0]};
      w_prod_next   = r_prod + w_partial;
      w_signed_prod = r_neg ? -w_prod_next : w_prod_next;
      w_sum         = w_signed_prod + r_acc;  // wraps modulo 2^(2*WIDTH)
   end

   // Datapath: operand latch, shift-add iteration and result capture on DONE entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_prod      <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_neg       <= 1'b0;
         r_long_op   <= 1'b0;
         r_cv        <= '0;
         r_result_lo <= '0;
         r_result_hi <= '0;
         r_nzcv      <= '0;
         r_long      <= 1'b0;
      end else if (w_load) begin
         r_mcand   <= {{WIDTH{1'b0}}, w_abs1};
         r_mplier  <= w_abs2;
         r_prod    <= '0;
         r_acc     <= w_acc_init;
         r_cnt     <= '0;
         r_neg     <= w_signed && (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
         r_long_op <= w_long;
         r_cv      <= i_nzcv[1:0];
      end else if (r_state == S_BUSY) begin
         r_mcand  <= r_mcand << BITS_PER_CYCLE;
         r_mplier <= r_mplier >> BITS_PER_CYCLE;
         r_prod   <= w_prod_next;
         r_cnt    <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_result_lo <= w_sum[WIDTH-1:0];
            r_result_hi <= r_long_op ? w_sum[PW-1:WIDTH] : '0;
            r_long      <= r_long_op;
            r_nzcv      <= r_long_op
                           ? {w_sum[PW-1],    (w_sum == '0),              r_cv}
                           : {w_sum[WIDTH-1], (w_sum[WIDTH-1:0] == '0),   r_cv};
         end
      end
   end

   assign o_busy      = (r_state == S_BUSY);
   assign o_done      = (r_state == S_DONE);
   assign o_result_lo = r_result_lo;
   assign o_result_hi = r_result_hi;
   assign o_nzcv      = r_nzcv;
   assign o_long      = r_long;

endmodule

// File: tb/tb_mult_unit.sv
`timescale 1ns/1ps
// tb_mult_unit: directed checks of mult_unit with WIDTH=32, BITS_PER_CYCLE=8
// (N=4). Latency is counted in edges after the edge that samples i_start;
// o_done is observed after the 4th such edge, the 5th counting the sampling edge.
module tb_mult_unit;

   logic        clk = 1'b0;
   logic        i_rst, i_start;
   logic [2:0]  i_opcode;
   logic [3:0]  i_nzcv;
   logic [31:0] i_op1, i_op2, i_acc_lo, i_acc_hi;
   logic        o_busy, o_done, o_long;
   logic [31:0] o_result_lo, o_result_hi;
   logic [3:0]  o_nzcv;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(8)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_opcode(i_opcode),
      .i_nzcv(i_nzcv), .i_op1(i_op1), .i_op2(i_op2), .i_acc_lo(i_acc_lo),
      .i_acc_hi(i_acc_hi), .o_busy(o_busy), .o_done(o_done),
      .o_result_lo(o_result_lo), .o_result_hi(o_result_hi), .o_nzcv(o_nzcv),
      .o_long(o_long)
   );

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Issue one operation, scramble inputs while busy, and count edges to o_done.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alo, input logic [31:0] ahi,
                         input logic [3:0] nz, input bit poke, output int edges);
      i_opcode = op; i_op1 = a; i_op2 = b; i_acc_lo = alo; i_acc_hi = ahi; i_nzcv = nz;
      i_start  = 1'b1;
      step();
      i_start  = 1'b0;
      i_opcode = 3'd3; i_op1 = 32'hDEADBEEF; i_op2 = 32'h12345678;
      i_acc_lo = 32'hCAFEF00D; i_acc_hi = 32'h0BADF00D; i_nzcv = 4'hF;
      edges = 0;
      for (int k = 0; k < 20; k++) begin
         if (poke && k == 1) i_start = 1'b1;
         if (poke && k == 2) i_start = 1'b0;
         step();
         edges++;
         if (o_done) break;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_start = 1'b1; i_opcode = 3'd2; i_nzcv = 4'hF;
      i_op1 = 32'hFFFFFFFF; i_op2 = 32'hFFFFFFFF; i_acc_lo = '0; i_acc_hi = '0;
      repeat (3) step();
      checks++;
      if ({o_busy, o_done, o_long, o_nzcv, o_result_lo, o_result_hi} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got busy=%b done=%b long=%b nzcv=%b lo=%h hi=%h exp all zero",
                  o_busy, o_done, o_long, o_nzcv, o_result_lo, o_result_hi);
      end
      i_rst = 1'b0; i_start = 1'b0;
      step();
      checks++;
      if (o_busy !== 1'b0) begin
         failures++; $display("FAIL reset_priority_busy got=%b exp=0", o_busy);
      end
   endtask

   task automatic test_umull();
      int e;
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 4'b0011, 1'b0, e);
      checks++;
      if (e !== 4) begin failures++; $display("FAIL umull_latency got=%0d exp=4", e); end
      checks++;
      if ({o_result_hi, o_result_lo} !== 64'hFFFFFFFE_00000001) begin
         failures++; $display("FAIL umull_result got=%h_%h exp=fffffffe_00000001", o_result_hi, o_result_lo);
      end
      checks++;
      if (o_nzcv !== 4'b1011 || o_long !== 1'b1) begin
         failures++; $display("FAIL umull_flags got nzcv=%b long=%b exp nzcv=1011 long=1", o_nzcv, o_long);
      end
   endtask

   task automatic test_smull();
      int e;
      run_op(3'd4, 32'h80000000, 32'h00000002, 32'h0, 32'h0, 4'b0000, 1'b0, e);
      checks++;
      if ({o_result_hi, o_result_lo} !== 64'hFFFFFFFF_00000000 || o_nzcv !== 4'b1000) begin
         failures++;
         $display("FAIL smull_neg got=%h_%h nzcv=%b exp=ffffffff_00000000 nzcv=1000",
                  o_result_hi, o_result_lo, o_nzcv);
      end
      run_op(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 4'b0010, 1'b0, e);
      checks++;
      if ({o_result_hi, o_result_lo} !== 64'h00000000_00000001 || o_nzcv !== 4'b0010) begin
         failures++;
         $display("FAIL smull_m1 got=%h_%h nzcv=%b exp=00000000_00000001 nzcv=0010",
                  o_result_hi, o_result_lo, o_nzcv);
      end
      run_op(3'd5, 32'hFFFFFFFE, 32'h00000003, 32'h0000000A, 32'h0, 4'b0000, 1'b0, e);
      checks++;
      if ({o_result_hi, o_result_lo} !== 64'h4 || o_long !== 1'b1) begin
         failures++;
         $display("FAIL smlal got=%h_%h long=%b exp=00000000_00000004 long=1", o_result_hi, o_result_lo, o_long);
      end
   endtask

   task automatic test_short_ops();
      int e;
      run_op(3'd1, 32'd3, 32'd5, 32'd7, 32'h55555555, 4'b1100, 1'b0, e);
      checks++;
      if (o_result_lo !== 32'h16 || o_result_hi !== 32'h0 || o_long !== 1'b0 || o_nzcv !== 4'b0000) begin
         failures++;
         $display("FAIL mla got lo=%h hi=%h long=%b nzcv=%b exp lo=16 hi=0 long=0 nzcv=0000",
                  o_result_lo, o_result_hi, o_long, o_nzcv);
      end
      run_op(3'd0, 32'h00010000, 32'h00010000, 32'd9, 32'd9, 4'b0001, 1'b0, e);
      checks++;
      if (o_result_lo !== 32'h0 || o_nzcv !== 4'b0101) begin
         failures++; $display("FAIL mul_zero got lo=%h nzcv=%b exp lo=0 nzcv=0101", o_result_lo, o_nzcv);
      end
      run_op(3'd7, 32'h12345678, 32'h00000010, 32'd5, 32'd5, 4'b0010, 1'b0, e);
      checks++;
      if (o_result_lo !== 32'h23456780 || o_result_hi !== 32'h0 || o_long !== 1'b0 || o_nzcv !== 4'b0010) begin
         failures++;
         $display("FAIL reserved got lo=%h hi=%h long=%b nzcv=%b exp lo=23456780 hi=0 long=0 nzcv=0010",
                  o_result_lo, o_result_hi, o_long, o_nzcv);
      end
   endtask

   task automatic test_umlal_poke();
      int e;
      run_op(3'd3, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h0, 4'b0000, 1'b1, e);
      checks++;
      if (e !== 4) begin failures++; $display("FAIL umlal_latency got=%0d exp=4", e); end
      checks++;
      if ({o_result_hi, o_result_lo} !== 64'h00000001_00000000 || o_nzcv !== 4'b0000) begin
         failures++;
         $display("FAIL umlal got=%h_%h nzcv=%b exp=00000001_00000000 nzcv=0000",
                  o_result_hi, o_result_lo, o_nzcv);
      end
      repeat (3) step();
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_result_lo !== 32'h0 || o_result_hi !== 32'h1) begin
         failures++;
         $display("FAIL hold got done=%b busy=%b lo=%h hi=%h exp done=0 busy=0 lo=0 hi=1",
                  o_done, o_busy, o_result_lo, o_result_hi);
      end
   endtask

   task automatic test_back_to_back();
      int dpos[3];
      int nd = 0, nbusy = 0;
      logic [31:0] res[3];
      i_opcode = 3'd0; i_op1 = 32'd3; i_op2 = 32'd5; i_acc_lo = '0; i_acc_hi = '0; i_nzcv = '0;
      i_start  = 1'b1;
      step();
      for (int e = 1; e <= 15; e++) begin
         step();
         if (o_busy) nbusy++;
         if (o_done) begin
            if (nd < 3) begin dpos[nd] = e; res[nd] = o_result_lo; end
            nd++;
            i_op2 = 32'd7;
         end
      end
      i_start = 1'b0;
      checks++;
      if (nd !== 3 || nbusy !== 12) begin
         failures++; $display("FAIL b2b_count got dones=%0d busy=%0d exp dones=3 busy=12", nd, nbusy);
      end else begin
         checks++;
         if (dpos[0] !== 4 || dpos[1] !== 9 || dpos[2] !== 14) begin
            failures++;
            $display("FAIL b2b_timing got=%0d,%0d,%0d exp=4,9,14", dpos[0], dpos[1], dpos[2]);
         end
         checks++;
         if (res[0] !== 32'd15 || res[1] !== 32'd21 || res[2] !== 32'd21) begin
            failures++;
            $display("FAIL b2b_results got=%0d,%0d,%0d exp=15,21,21", res[0], res[1], res[2]);
         end
      end
      for (int k = 0; k < 10 && !o_done; k++) step();
      step();
   endtask

   task automatic test_reset_abort();
      int e, nd = 0;
      i_opcode = 3'd2; i_op1 = 32'hFFFFFFFF; i_op2 = 32'h2; i_acc_lo = '0; i_acc_hi = '0; i_nzcv = 4'b0011;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      step();
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      checks++;
      if ({o_busy, o_done, o_long, o_nzcv, o_result_lo, o_result_hi} !== '0) begin
         failures++;
         $display("FAIL abort_outputs got busy=%b done=%b long=%b nzcv=%b lo=%h hi=%h exp all zero",
                  o_busy, o_done, o_long, o_nzcv, o_result_lo, o_result_hi);
      end
      for (int k = 0; k < 10; k++) begin step(); if (o_done) nd++; end
      checks++;
      if (nd !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
      run_op(3'd0, 32'd6, 32'd7, 32'h0, 32'h0, 4'b0000, 1'b0, e);
      checks++;
      if (e !== 4 || o_result_lo !== 32'd42) begin
         failures++; $display("FAIL abort_recover got edges=%0d lo=%0d exp edges=4 lo=42", e, o_result_lo);
      end
   endtask

   initial begin
      test_reset();
      test_umull();
      test_smull();
      test_short_ops();
      test_umlal_poke();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
